// File: rtl/mul_pkg.sv
// Shared encodings, the stage-1 payload type and operand sign helpers
// for the pipelined RV32M multiply unit.
package mul_pkg;

  localparam logic [1:0] FUNCT_MUL    = 2'b00;
  localparam logic [1:0] FUNCT_MULH   = 2'b01;
  localparam logic [1:0] FUNCT_MULHSU = 2'b10;
  localparam logic [1:0] FUNCT_MULHU  = 2'b11;

  // The tag travels next to this payload because its width is a parameter of the unit.
  typedef struct packed {
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        neg;
    logic [1:0]  funct;
  } s1_payload_t;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    logic [31:0] m;
    if (is_signed && v[31]) begin
      m = ~v + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  function automatic logic [63:0] negate64(input logic [63:0] v, input logic do_neg);
    logic [63:0] r;
    if (do_neg) begin
      r = ~v + 64'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/Mul32U.sv
// Combinational 32x32 unsigned array multiplier producing the full 64-bit product.
module Mul32U (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  logic [63:0] acc_s;

  // Sum of the partial-product rows; row i is a shifted by i, gated by b[i].
  always_comb begin
    acc_s = 64'd0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        acc_s = acc_s + ({32'd0, a} << i);
      end else begin
        acc_s = acc_s;
      end
    end
  end

  assign p = acc_s;

endmodule

// File: rtl/mul32_unit.sv
// Two-stage RV32M multiply unit: sign normalisation into S1, then
// unsigned multiply, sign restore and half-select into the output register.
module mul32_unit
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_funct,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  s1_payload_t      s1_d, s1_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;
  logic             s1_valid_d, s1_valid_q;
  logic             out_valid_d, out_valid_q;
  logic [31:0]      out_data_d, out_data_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  logic             adv_s;
  logic             accept_s;
  logic             op1_signed_s, op2_signed_s;
  s1_payload_t      new_s1_s;
  logic [63:0]      product_s;
  logic [63:0]      result_s;
  logic [31:0]      result_half_s;

  // Output takes S1 whenever it is empty or being drained; S1 follows in lockstep.
  assign adv_s    = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv_s;
  assign accept_s = in_valid && in_ready;

  // Operand signedness: op1 signed for MULH/MULHSU, op2 signed for MULH only.
  always_comb begin
    op1_signed_s = 1'b0;
    op2_signed_s = 1'b0;
    case (in_funct)
      FUNCT_MULH: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b1;
      end
      FUNCT_MULHSU: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b0;
      end
      FUNCT_MUL, FUNCT_MULHU: begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
      end
      default: begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
      end
    endcase
  end

  assign new_s1_s.mag1  = magnitude(in_op1, op1_signed_s);
  assign new_s1_s.mag2  = magnitude(in_op2, op2_signed_s);
  assign new_s1_s.neg   = (op1_signed_s & in_op1[31]) ^ (op2_signed_s & in_op2[31]);
  assign new_s1_s.funct = in_funct;

  Mul32U u_mul (
    .a (s1_q.mag1),
    .b (s1_q.mag2),
    .p (product_s)
  );

  assign result_s = negate64(product_s, s1_q.neg);

  // Low half only for MUL; every high-half variant returns bits 63:32.
  always_comb begin
    result_half_s = result_s[63:32];
    case (s1_q.funct)
      FUNCT_MUL: result_half_s = result_s[31:0];
      default:   result_half_s = result_s[63:32];
    endcase
  end

  // Stage-1 next state; flush wins over accept and advance.
  always_comb begin
    s1_d       = s1_q;
    s1_tag_d   = s1_tag_q;
    s1_valid_d = s1_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_d       = new_s1_s;
      s1_tag_d   = in_tag;
    end else if (adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Output next state; payload only changes when a valid S1 entry moves in.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = result_half_s;
        out_tag_d  = s1_tag_q;
      end else begin
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_tag_q    <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_tag_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_tag_q    <= s1_tag_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule
